// File: rtl/apb_regs_pkg.sv
// Shared definitions for the APB CSR bank: per-bit access-type codes,
// the bus FSM state type, and the reset value each access type powers up with.
package apb_regs_pkg;

   typedef logic [3:0] reg_type_t;

   localparam reg_type_t ZR     = 4'd0;
   localparam reg_type_t RO     = 4'd1;
   localparam reg_type_t RW_0   = 4'd2;
   localparam reg_type_t RW_1   = 4'd3;
   localparam reg_type_t RWE_0  = 4'd4;
   localparam reg_type_t RWE_1  = 4'd5;
   localparam reg_type_t RW1E_0 = 4'd6;
   localparam reg_type_t RW1E_1 = 4'd7;
   localparam reg_type_t W1C    = 4'd8;
   localparam reg_type_t W1O    = 4'd9;
   localparam reg_type_t RWC    = 4'd10;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS
   } apb_state_t;

   // Only the "_1" flavours come out of reset set; everything else clears.
   function automatic logic reg_rst_val(input reg_type_t t);
      return (t == RW_1) || (t == RWE_1) || (t == RW1E_1);
   endfunction

endpackage

// File: rtl/apb_csr_bank_bit.sv
// One register bit cell; TYPE selects how bus writes and the fabric input
// combine into the stored bit, what the fabric sees and what a read returns.
module csr_bit
   import apb_regs_pkg::*;
#(
   parameter reg_type_t TYPE = RW_0
) (
   input  logic clk,
   input  logic resetn,
   input  logic wr_en,
   input  logic wdata,
   input  logic in,
   output logic q,
   output logic rd
);

   localparam logic RST_VAL = reg_rst_val(TYPE);

   logic r_bit;
   logic w_unused;

   assign w_unused = &{1'b0, wr_en, wdata, in};

   // Fabric-side set/clear takes priority over a bus write in the same cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_bit <= RST_VAL;
      end else begin
         case (TYPE)
            RW_0, RW_1:     if (wr_en) r_bit <= wdata;
            RWE_0, RWE_1:   if (wr_en && in) r_bit <= wdata;
            RW1E_0, RW1E_1: if (wr_en && (!wdata || in)) r_bit <= wdata;
            W1C: begin
               if (in)                  r_bit <= 1'b1;
               else if (wr_en && wdata) r_bit <= 1'b0;
            end
            W1O:            r_bit <= wr_en & wdata;
            RWC: begin
               if (in)         r_bit <= 1'b0;
               else if (wr_en) r_bit <= wdata;
            end
            default:        r_bit <= 1'b0;
         endcase
      end
   end

   always_comb begin
      q  = 1'b0;
      rd = 1'b0;
      case (TYPE)
         RO: rd = in;
         RW_0, RW_1, RWE_0, RWE_1, RW1E_0, RW1E_1, RWC: begin
            q  = r_bit;
            rd = r_bit;
         end
         W1C: rd = r_bit;
         W1O: begin
            q  = r_bit;
            rd = in;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/apb_csr_bank.sv
// Parametrised APB control/status register bank: bus FSM with wait states,
// address/alignment/privilege fault decode, registered read mux and bit cells.
module apb_csr_bank
   import apb_regs_pkg::*;
#(
   parameter int                         REGS_NUM    = 8,
   parameter int                         ADDR_W      = 12,
   parameter logic [REGS_NUM*32*4-1:0]   REG_TYPES   = {REGS_NUM*32{RW_0}},
   parameter int                         WAIT_STATES = 0,
   parameter logic [REGS_NUM-1:0]        PRIV_MASK   = '0
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     apb_psel,
   input  logic                     apb_penable,
   input  logic [ADDR_W-1:0]        apb_paddr,
   input  logic                     apb_pwrite,
   input  logic [DATA_W-1:0]        apb_pwdata,
   input  logic [3:0]               apb_pstrb,
   input  logic [2:0]               apb_pprot,
   output logic [DATA_W-1:0]        apb_prdata,
   output logic                     apb_pready,
   output logic                     apb_pslverr,
   output logic [REGS_NUM*32-1:0]   reg_outputs,
   input  logic [REGS_NUM*32-1:0]   reg_inputs,
   output logic [REGS_NUM-1:0]      reg_wr_pulse
);

   localparam int IDX_W = ADDR_W - 2;

   apb_state_t          r_state;
   logic [3:0]          r_cnt;
   logic                r_fault;
   logic [IDX_W-1:0]    r_idx;
   logic [DATA_W-1:0]   r_prdata;
   logic [REGS_NUM-1:0] r_wrPulse;

   logic [IDX_W-1:0]    w_idx;
   logic [REGS_NUM*32-1:0] w_rdArr;
   logic [DATA_W-1:0]   w_rdWord;
   logic                w_priv;
   logic                w_fault;
   logic                w_pready;
   logic                w_commit;
   logic [REGS_NUM-1:0] w_wrReg;
   logic                w_unused;

   assign w_idx    = apb_paddr[ADDR_W-1:2];
   assign w_unused = &{1'b0, apb_pprot[2:1]};

   // Read mux and privilege lookup share one index decode.
   always_comb begin
      w_rdWord = '0;
      w_priv   = 1'b0;
      for (int i = 0; i < REGS_NUM; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_rdWord = w_rdArr[i*32 +: 32];
            w_priv   = PRIV_MASK[i];
         end
      end
   end

   assign w_fault = (32'(w_idx) >= 32'(REGS_NUM)) ||
                    (apb_paddr[1:0] != 2'b00) ||
                    (w_priv && !apb_pprot[0]);

   assign w_pready = (r_state == S_ACCESS) && (r_cnt == 4'd0);
   assign w_commit = apb_psel && apb_penable && apb_pwrite && w_pready && !r_fault;

   assign apb_pready   = w_pready;
   assign apb_pslverr  = r_fault && w_pready;
   assign apb_prdata   = r_prdata;
   assign reg_wr_pulse = r_wrPulse;

   // Fault, index and read data are captured when SETUP ends so the access
   // phase sees stable values even if the fabric inputs move meanwhile.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_fault   <= 1'b0;
         r_idx     <= '0;
         r_prdata  <= '0;
         r_wrPulse <= '0;
      end else begin
         r_wrPulse <= w_wrReg;
         case (r_state)
            S_IDLE: begin
               if (apb_psel && !apb_penable) r_state <= S_SETUP;
            end
            S_SETUP: begin
               r_state  <= S_ACCESS;
               r_cnt    <= 4'(WAIT_STATES);
               r_fault  <= w_fault;
               r_idx    <= w_idx;
               r_prdata <= w_fault ? '0 : w_rdWord;
            end
            S_ACCESS: begin
               if (!apb_psel) begin
                  r_state  <= S_IDLE;
                  r_prdata <= '0;
               end else if (r_cnt != 4'd0) begin
                  r_cnt <= r_cnt - 4'd1;
               end else begin
                  r_prdata <= '0;
                  r_state  <= (apb_psel && !apb_penable) ? S_SETUP : S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar i = 0; i < REGS_NUM; i++) begin : g_reg
      assign w_wrReg[i] = w_commit && (r_idx == IDX_W'(i));
      for (genvar j = 0; j < 32; j++) begin : g_bit
         csr_bit #(
            .TYPE (REG_TYPES[(i*32+j)*4 +: 4])
         ) u_bit (
            .clk    (clk),
            .resetn (resetn),
            .wr_en  (w_wrReg[i] & apb_pstrb[j/8]),
            .wdata  (apb_pwdata[j]),
            .in     (reg_inputs[i*32+j]),
            .q      (reg_outputs[i*32+j]),
            .rd     (w_rdArr[i*32+j])
         );
      end
   end

endmodule

// File: tb/tb_apb_csr_bank.sv
// Self-checking bench for apb_csr_bank: directed and random APB transfers,
// expectations from a word-level register model, checked by a pready monitor.
module tb_apb_csr_bank;
   import apb_regs_pkg::*;

   localparam int NREG = 8;
   localparam int AW   = 12;
   localparam int WS   = 3;
   localparam logic [NREG-1:0] PRIV = 8'b0000_0010;
   localparam logic [31:0] ZR_HI = 32'hFFFF_0000;
   localparam logic [32:0] NO_OVR = 33'h0;

   // Register map: one access type per register; reg7's upper half is ZR.
   function automatic reg_type_t regType(input int i);
      case (i)
         0: return RW_0;
         1: return RW_1;
         2: return RO;
         3: return W1C;
         4: return W1O;
         5: return RWE_0;
         6: return RW1E_1;
         default: return RWC;
      endcase
   endfunction

   function automatic logic [NREG*32*4-1:0] buildTypes();
      logic [NREG*32*4-1:0] v;
      v = '0;
      for (int i = 0; i < NREG; i++)
         for (int j = 0; j < 32; j++)
            v[(i*32+j)*4 +: 4] = (i == 7 && j >= 16) ? ZR : regType(i);
      return v;
   endfunction

   localparam logic [NREG*32*4-1:0] TB_TYPES = buildTypes();

   function automatic logic [31:0] zrMask(input int i);
      return (i == 7) ? ZR_HI : 32'h0;
   endfunction

   logic                 clk;
   logic                 resetn;
   logic                 apb_psel;
   logic                 apb_penable;
   logic [AW-1:0]        apb_paddr;
   logic                 apb_pwrite;
   logic [31:0]          apb_pwdata;
   logic [3:0]           apb_pstrb;
   logic [2:0]           apb_pprot;
   logic [31:0]          apb_prdata;
   logic                 apb_pready;
   logic                 apb_pslverr;
   logic [NREG*32-1:0]   reg_outputs;
   logic [NREG*32-1:0]   reg_inputs;
   logic [NREG-1:0]      reg_wr_pulse;

   apb_csr_bank #(
      .REGS_NUM    (NREG),
      .ADDR_W      (AW),
      .REG_TYPES   (TB_TYPES),
      .WAIT_STATES (WS),
      .PRIV_MASK   (PRIV)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .apb_psel     (apb_psel),
      .apb_penable  (apb_penable),
      .apb_paddr    (apb_paddr),
      .apb_pwrite   (apb_pwrite),
      .apb_pwdata   (apb_pwdata),
      .apb_pstrb    (apb_pstrb),
      .apb_pprot    (apb_pprot),
      .apb_prdata   (apb_prdata),
      .apb_pready   (apb_pready),
      .apb_pslverr  (apb_pslverr),
      .reg_outputs  (reg_outputs),
      .reg_inputs   (reg_inputs),
      .reg_wr_pulse (reg_wr_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: stored register words and current fabric inputs.
   logic [31:0] mReg [NREG];
   logic [31:0] mIn  [NREG];

   task automatic modelReset();
      for (int i = 0; i < NREG; i++)
         mReg[i] = (regType(i) inside {RW_1, RWE_1, RW1E_1}) ? 32'hFFFF_FFFF : 32'h0;
   endtask

   // Fabric inputs act every cycle and win over a same-cycle bus write.
   task automatic modelSteady();
      for (int i = 0; i < NREG; i++) begin
         if (regType(i) == W1C) mReg[i] = mReg[i] | mIn[i];
         if (regType(i) == RWC) mReg[i] = mReg[i] & ~mIn[i];
      end
   endtask

   function automatic logic [31:0] strbMask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   task automatic modelWrite(input int i, input logic [31:0] d, input logic [3:0] s, output logic [31:0] pulse);
      logic [31:0] m;
      m = strbMask(s);
      pulse = 32'h0;
      case (regType(i))
         RW_0, RW_1, RWC: mReg[i] = (mReg[i] & ~m) | (d & m);
         RWE_0, RWE_1:    mReg[i] = (mReg[i] & ~(m & mIn[i])) | (d & m & mIn[i]);
         RW1E_0, RW1E_1:  mReg[i] = (mReg[i] & ~(m & ~d)) | (m & d & mIn[i]);
         W1C:             mReg[i] = mReg[i] & ~(m & d);
         W1O:             pulse = m & d;
         default: ;
      endcase
      modelSteady();
   endtask

   function automatic logic [31:0] readExp(input int i);
      logic [31:0] v;
      case (regType(i))
         RO, W1O: v = mIn[i];
         ZR:      v = 32'h0;
         default: v = mReg[i];
      endcase
      return v & ~zrMask(i);
   endfunction

   function automatic logic [31:0] outExp(input int i);
      case (regType(i))
         RW_0, RW_1, RWE_0, RWE_1, RW1E_0, RW1E_1, RWC: return mReg[i] & ~zrMask(i);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [NREG*32-1:0] outVec(input int pIdx, input logic [31:0] pVal);
      logic [NREG*32-1:0] v;
      for (int i = 0; i < NREG; i++)
         v[i*32 +: 32] = (i == pIdx && regType(i) == W1O) ? pVal : outExp(i);
      return v;
   endfunction

   typedef struct {
      logic        isRead;
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t sbQ [$];
   exp_t monE;

   // Scoreboard monitor: every completed transfer consumes one expectation.
   always @(negedge clk) begin
      if (resetn && apb_pready) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_pready", 256'(apb_pready), 256'(0));
         end else begin
            monE = sbQ.pop_front();
            checkOutput("pslverr", 256'(apb_pslverr), 256'(monE.err));
            if (monE.isRead) checkOutput("prdata", 256'(apb_prdata), 256'(monE.rd));
         end
      end
   end

   task automatic driveIn();
      for (int i = 0; i < NREG; i++) reg_inputs[i*32 +: 32] = mIn[i];
   endtask

   task automatic setInputs(input int i, input logic [31:0] v);
      @(posedge clk);
      #1;
      mIn[i] = v;
      driveIn();
      modelSteady();
   endtask

   task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [2:0] prot, input logic [32:0] expOvr);
      int idx;
      int waitCnt;
      logic fault;
      logic priv;
      exp_t e;
      logic [31:0] pulse;
      logic [NREG-1:0] expPulse;
      idx   = int'(addr[AW-1:2]);
      priv  = (idx < NREG) ? PRIV[idx] : 1'b0;
      fault = (idx >= NREG) || (addr[1:0] != 2'b00) || (priv && !prot[0]);
      e.isRead = !wr;
      e.err    = fault;
      if (fault) e.rd = 32'h0;
      else       e.rd = readExp(idx);
      if (expOvr[32]) e.rd = expOvr[31:0];
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = addr; apb_pwrite = wr;
      apb_pwdata = data; apb_pstrb = strb; apb_pprot = prot;
      @(posedge clk);
      #1;
      apb_penable = 1'b1;
      waitCnt = 0;
      @(negedge clk);
      while (!apb_pready && waitCnt < 64) begin
         waitCnt++;
         @(negedge clk);
      end
      checkOutput("pready_latency", 256'(waitCnt), 256'(WS + 1));
      if (!apb_pready) begin
         sbQ.delete(sbQ.size() - 1);
         #1;
         apb_psel = 1'b0; apb_penable = 1'b0;
         return;
      end
      checkOutput("outputs_before_commit", 256'(reg_outputs), 256'(outVec(-1, 32'h0)));
      @(posedge clk);
      #1;
      apb_psel = 1'b0; apb_penable = 1'b0;
      pulse = 32'h0;
      expPulse = '0;
      if (wr && !fault) begin
         modelWrite(idx, data, strb, pulse);
         expPulse[idx] = 1'b1;
      end
      @(negedge clk);
      checkOutput("wr_pulse", 256'(reg_wr_pulse), 256'(expPulse));
      checkOutput("outputs_after_commit", 256'(reg_outputs), 256'(outVec(idx, pulse)));
      @(negedge clk);
      checkOutput("wr_pulse_clear", 256'(reg_wr_pulse), 256'(0));
      checkOutput("outputs_settled", 256'(reg_outputs), 256'(outVec(-1, 32'h0)));
      checkOutput("prdata_cleared", 256'(apb_prdata), 256'(0));
   endtask

   task automatic abortXfer();
      @(posedge clk);
      #1;
      apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 12'h000; apb_pwrite = 1'b1;
      apb_pwdata = 32'hDEAD_BEEF; apb_pstrb = 4'hF; apb_pprot = 3'b001;
      @(posedge clk);
      #1;
      apb_penable = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      apb_psel = 1'b0; apb_penable = 1'b0;
      repeat (6) begin
         @(negedge clk);
         checkOutput("abort_no_pready", 256'(apb_pready), 256'(0));
      end
      checkOutput("abort_no_commit", 256'(reg_outputs), 256'(outVec(-1, 32'h0)));
      checkOutput("abort_no_pulse", 256'(reg_wr_pulse), 256'(0));
   endtask

   task automatic resetMidXfer();
      @(posedge clk);
      #1;
      apb_psel = 1'b1; apb_penable = 1'b0; apb_paddr = 12'h000; apb_pwrite = 1'b1;
      apb_pwdata = 32'h1234_5678; apb_pstrb = 4'hF; apb_pprot = 3'b001;
      @(posedge clk);
      #1;
      apb_penable = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      resetn = 1'b0;
      #1;
      modelReset();
      checkOutput("rst_pready", 256'(apb_pready), 256'(0));
      checkOutput("rst_pslverr", 256'(apb_pslverr), 256'(0));
      checkOutput("rst_prdata", 256'(apb_prdata), 256'(0));
      checkOutput("rst_wr_pulse", 256'(reg_wr_pulse), 256'(0));
      checkOutput("rst_outputs", 256'(reg_outputs), 256'(outVec(-1, 32'h0)));
      apb_psel = 1'b0; apb_penable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      modelSteady();
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int idx;
      logic [AW-1:0] addr;
      resetn = 1'b0;
      apb_psel = 1'b0; apb_penable = 1'b0; apb_paddr = '0; apb_pwrite = 1'b0;
      apb_pwdata = '0; apb_pstrb = '0; apb_pprot = '0;
      for (int i = 0; i < NREG; i++) mIn[i] = 32'h0;
      driveIn();
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_pready", 256'(apb_pready), 256'(0));
      checkOutput("reset_pslverr", 256'(apb_pslverr), 256'(0));
      checkOutput("reset_prdata", 256'(apb_prdata), 256'(0));
      checkOutput("reset_wr_pulse", 256'(reg_wr_pulse), 256'(0));
      checkOutput("reset_outputs", 256'(reg_outputs), 256'(outVec(-1, 32'h0)));
      resetn = 1'b1;

      applyStimulus(12'h000, 1'b1, 32'hA5A5_1234, 4'hF, 3'b001, NO_OVR);
      applyStimulus(12'h000, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'hA5A5_1234});
      applyStimulus(12'h000, 1'b1, 32'h0000_0001, 4'hF, 3'b001, NO_OVR);

      applyStimulus(12'h020, 1'b1, 32'hFFFF_FFFF, 4'hF, 3'b001, NO_OVR);
      applyStimulus(12'h002, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'h0});
      applyStimulus(12'h004, 1'b1, 32'h0, 4'hF, 3'b000, NO_OVR);
      applyStimulus(12'h004, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'hFFFF_FFFF});

      applyStimulus(12'h000, 1'b1, 32'h0, 4'hF, 3'b001, NO_OVR);
      applyStimulus(12'h000, 1'b1, 32'hFFFF_FFFF, 4'b0101, 3'b001, NO_OVR);
      applyStimulus(12'h000, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'h00FF_00FF});

      setInputs(3, 32'h0000_0001);
      applyStimulus(12'h00C, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'h0000_0001});
      applyStimulus(12'h00C, 1'b1, 32'h0000_0001, 4'hF, 3'b001, NO_OVR);
      applyStimulus(12'h00C, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'h0000_0001});
      setInputs(3, 32'h0);
      applyStimulus(12'h00C, 1'b1, 32'h0000_0001, 4'hF, 3'b001, NO_OVR);
      applyStimulus(12'h00C, 1'b0, 32'h0, 4'h0, 3'b001, {1'b1, 32'h0});

      applyStimulus(12'h010, 1'b1, 32'h0000_0001, 4'hF, 3'b001, NO_OVR);

      abortXfer();
      applyStimulus(12'h000, 1'b0, 32'h0, 4'h0, 3'b001, NO_OVR);

      for (int n = 0; n < 70; n++) begin
         if ($urandom_range(0, 3) == 0) setInputs(int'($urandom_range(0, NREG - 1)), $urandom);
         idx  = int'($urandom_range(0, 9));
         addr = AW'(idx * 4);
         if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
         applyStimulus(addr, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                       3'($urandom_range(0, 7)), NO_OVR);
      end

      resetMidXfer();
      for (int i = 0; i < NREG; i++)
         applyStimulus(AW'(i * 4), 1'b0, 32'h0, 4'h0, 3'b001, NO_OVR);

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_drained", 256'(sbQ.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
